gmii_rx_checker: RTL and testbench



---
 rtl/gmii_rx_checker.sv | 206 ++++++++++++++++++++
 tb/tb_gmii_rx_checker.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_rx_checker.sv
// GMII receive frame checker: strips preamble/SFD, captures DA/SA/type, checks length and FCS, counts frames.
// Build option: define GMII_RX_PAYLOAD_CMP_EN to add the incrementing-payload compare and the pld_err output.
module gmii_rx_checker #(
  parameter int MIN_FRAME = 64,
  parameter int MAX_FRAME = 1518,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  input  logic             cnt_clr,
  output logic             frame_done,
  output logic             frame_ok,
  output logic             crc_err,
  output logic             len_err,
  output logic             rx_err_seen,
  output logic [10:0]      frame_len,
  output logic [47:0]      dst_mac,
  output logic [47:0]      src_mac,
  output logic [15:0]      eth_type,
`ifdef GMII_RX_PAYLOAD_CMP_EN
  output logic             pld_err,
`endif
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] bad_cnt
);

  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

  localparam logic [10:0] MIN_LEN  = 11'(MIN_FRAME);
  localparam logic [10:0] MAX_LEN  = 11'(MAX_FRAME);
  localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;

  state_t      state;
  logic [10:0] byte_cnt_p0;
  logic        err_p0;
  logic [31:0] crc_p0;
  logic [47:0] dst_p0;
  logic [47:0] src_p0;
  logic [15:0] type_p0;

  logic sfd_hit;
  logic data_beat;
  logic eof;
  logic crc_bad_c;
  logic len_bad_c;
  logic pld_bad_c;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [10:0] len_inc(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  assign sfd_hit   = (state == PRE) && gmii_rx_dv && (gmii_rxd == 8'hD5);
  assign data_beat = (state == DATA) && gmii_rx_dv;
  assign eof       = (state == DATA) && !gmii_rx_dv;

  always_comb begin
    crc_bad_c = (crc_p0 != CRC_RES);
    len_bad_c = (byte_cnt_p0 < MIN_LEN) || (byte_cnt_p0 > MAX_LEN);
  end

  // Stage p0: frame framing FSM, byte count and sticky receive error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      byte_cnt_p0 <= '0;
      err_p0      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gmii_rx_dv) begin
            err_p0 <= 1'b0;
            state  <= (gmii_rxd == 8'h55) ? PRE : DROP;
          end
        end
        PRE: begin
          if (!gmii_rx_dv) begin
            state <= IDLE;
          end else begin
            // an errored preamble byte still lets the frame through so it gets reported
            if (gmii_rx_er) err_p0 <= 1'b1;
            if (gmii_rxd == 8'hD5) begin
              state       <= DATA;
              byte_cnt_p0 <= '0;
            end else if (gmii_rxd != 8'h55) begin
              state <= DROP;
            end
          end
        end
        DATA: begin
          if (gmii_rx_dv) begin
            if (gmii_rx_er) err_p0 <= 1'b1;
            byte_cnt_p0 <= len_inc(byte_cnt_p0);
          end else begin
            state <= IDLE;
          end
        end
        DROP: begin
          if (!gmii_rx_dv) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (sfd_hit) begin
      crc_p0  <= 32'hFFFF_FFFF;
      dst_p0  <= '0;
      src_p0  <= '0;
      type_p0 <= '0;
    end else if (data_beat) begin
      crc_p0 <= crc32_byte(crc_p0, gmii_rxd);
      if (byte_cnt_p0 < 11'd6) begin
        dst_p0 <= {dst_p0[39:0], gmii_rxd};
      end else if (byte_cnt_p0 < 11'd12) begin
        src_p0 <= {src_p0[39:0], gmii_rxd};
      end else if (byte_cnt_p0 < 11'd14) begin
        type_p0 <= {type_p0[7:0], gmii_rxd};
      end
    end
  end

`ifdef GMII_RX_PAYLOAD_CMP_EN
  logic [7:0] pat_p0;
  logic [3:0] mis_p0;
  logic       pld_acc_p0;

  // A byte is only known to be payload (not FCS) once four more bytes follow it,
  // so mismatch flags ride a 4-deep delay line before being accumulated.
  always_ff @(posedge clk) begin
    if (sfd_hit) begin
      pat_p0     <= 8'h01;
      mis_p0     <= '0;
      pld_acc_p0 <= 1'b0;
    end else if (data_beat) begin
      mis_p0     <= {mis_p0[2:0], (byte_cnt_p0 >= 11'd14) && (gmii_rxd != pat_p0)};
      pld_acc_p0 <= pld_acc_p0 | mis_p0[3];
      if (byte_cnt_p0 >= 11'd14) pat_p0 <= pat_p0 + 8'd1;
    end
  end

  assign pld_bad_c = pld_acc_p0;
`else
  assign pld_bad_c = 1'b0;
`endif

  // Stage p1: per-frame status registers and frame counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done  <= 1'b0;
      frame_ok    <= 1'b0;
      crc_err     <= 1'b0;
      len_err     <= 1'b0;
      rx_err_seen <= 1'b0;
      frame_len   <= '0;
      dst_mac     <= '0;
      src_mac     <= '0;
      eth_type    <= '0;
`ifdef GMII_RX_PAYLOAD_CMP_EN
      pld_err     <= 1'b0;
`endif
      good_cnt    <= '0;
      bad_cnt     <= '0;
    end else begin
      frame_done <= eof;
      if (eof) begin
        frame_ok    <= !(crc_bad_c || len_bad_c || err_p0 || pld_bad_c);
        crc_err     <= crc_bad_c;
        len_err     <= len_bad_c;
        rx_err_seen <= err_p0;
        frame_len   <= byte_cnt_p0;
        dst_mac     <= dst_p0;
        src_mac     <= src_p0;
        eth_type    <= type_p0;
`ifdef GMII_RX_PAYLOAD_CMP_EN
        pld_err     <= pld_bad_c;
`endif
      end
      if (cnt_clr) begin
        good_cnt <= '0;
        bad_cnt  <= '0;
      end else if (frame_done) begin
        if (frame_ok) good_cnt <= cnt_inc(good_cnt);
        else          bad_cnt  <= cnt_inc(bad_cnt);
      end
    end
  end

endmodule

// File: tb/tb_gmii_rx_checker.sv
// Scoreboard bench for gmii_rx_checker: frames are queued with expected status and checked on frame_done.
`timescale 1ns/1ps
module tb_gmii_rx_checker;
  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       gmii_rxd = 8'h00;
  logic             gmii_rx_dv = 1'b0;
  logic             gmii_rx_er = 1'b0;
  logic             cnt_clr = 1'b0;
  logic             frame_done, frame_ok, crc_err, len_err, rx_err_seen;
  logic [10:0]      frame_len;
  logic [47:0]      dst_mac, src_mac;
  logic [15:0]      eth_type;
  logic [CNT_W-1:0] good_cnt, bad_cnt;
  logic             pld_err;

  gmii_rx_checker #(.MIN_FRAME(64), .MAX_FRAME(1518), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .gmii_rxd(gmii_rxd), .gmii_rx_dv(gmii_rx_dv),
    .gmii_rx_er(gmii_rx_er), .cnt_clr(cnt_clr), .frame_done(frame_done),
    .frame_ok(frame_ok), .crc_err(crc_err), .len_err(len_err),
    .rx_err_seen(rx_err_seen), .frame_len(frame_len), .dst_mac(dst_mac),
    .src_mac(src_mac), .eth_type(eth_type),
`ifdef GMII_RX_PAYLOAD_CMP_EN
    .pld_err(pld_err),
`endif
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

`ifndef GMII_RX_PAYLOAD_CMP_EN
  assign pld_err = 1'b0;
`endif

  always #4 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [160:0] all_out;
  assign all_out = {pld_err, frame_done, frame_ok, crc_err, len_err, rx_err_seen,
                    frame_len, dst_mac, src_mac, eth_type, good_cnt, bad_cnt};

  typedef struct {
    bit          ok, crc, len_e, rxe, pld, chk_hdr;
    logic [10:0] len;
    logic [47:0] dst, src;
    logic [15:0] typ;
    int          cyc;
  } exp_t;

  exp_t       sb[$];
  exp_t       m_e;
  logic [7:0] frm[$];
  int         n_cmp = 0, n_bad = 0, done_cnt = 0;
  logic       prev_done = 1'b0;

  // Scoreboard monitor: every frame_done pops one expected record.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0;
    end else begin
      if (prev_done) begin
        n_cmp++;
        if (frame_done !== 1'b0) begin
          n_bad++;
          $display("FAIL done_width: got frame_done=%b required 0 on second cycle", frame_done);
        end
      end
      if (frame_done) begin
        done_cnt++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_done: got frame_done=1 at cycle %0d required no report", cyc);
        end else begin
          m_e = sb.pop_front();
          n_cmp += 5;
          if (cyc !== m_e.cyc + 1) begin
            n_bad++; $display("FAIL done_latency: got cycle %0d required %0d", cyc, m_e.cyc + 1);
          end
          if (frame_ok !== m_e.ok) begin
            n_bad++; $display("FAIL frame_ok: got %b required %b", frame_ok, m_e.ok);
          end
          if (crc_err !== m_e.crc) begin
            n_bad++; $display("FAIL crc_err: got %b required %b", crc_err, m_e.crc);
          end
          if (len_err !== m_e.len_e) begin
            n_bad++; $display("FAIL len_err: got %b required %b", len_err, m_e.len_e);
          end
          if (rx_err_seen !== m_e.rxe) begin
            n_bad++; $display("FAIL rx_err_seen: got %b required %b", rx_err_seen, m_e.rxe);
          end
          if (frame_len !== m_e.len) begin
            n_bad++; $display("FAIL frame_len: got %0d required %0d", frame_len, m_e.len);
          end
`ifdef GMII_RX_PAYLOAD_CMP_EN
          n_cmp++;
          if (pld_err !== m_e.pld) begin
            n_bad++; $display("FAIL pld_err: got %b required %b", pld_err, m_e.pld);
          end
`endif
          if (m_e.chk_hdr) begin
            n_cmp += 3;
            if (dst_mac !== m_e.dst) begin
              n_bad++; $display("FAIL dst_mac: got %h required %h", dst_mac, m_e.dst);
            end
            if (src_mac !== m_e.src) begin
              n_bad++; $display("FAIL src_mac: got %h required %h", src_mac, m_e.src);
            end
            if (eth_type !== m_e.typ) begin
              n_bad++; $display("FAIL eth_type: got %h required %h", eth_type, m_e.typ);
            end
          end
        end
      end
      prev_done = frame_done;
    end
  end

  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int b = 0; b < 8; b++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
    return r;
  endfunction

  // DA = da0:02:03:04:05:06, SA = 5A:02:03:04:05:06, payload 01,02,... and a valid FCS.
  task automatic build_frame(input int total, input logic [7:0] da0);
    logic [31:0] c;
    logic [15:0] t;
    frm.delete();
    frm.push_back(da0);
    for (int k = 2; k <= 6; k++) frm.push_back(8'(k));
    frm.push_back(8'h5A);
    for (int k = 2; k <= 6; k++) frm.push_back(8'(k));
    t = 16'(total - 18);
    frm.push_back(t[15:8]);
    frm.push_back(t[7:0]);
    for (int k = 0; k < total - 18; k++) frm.push_back(8'(k + 1));
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_next(c, frm[i]);
    c = ~c;
    frm.push_back(c[7:0]);
    frm.push_back(c[15:8]);
    frm.push_back(c[23:16]);
    frm.push_back(c[31:24]);
  endtask

  task automatic drive(input logic [7:0] d, input logic v, input logic e);
    @(posedge clk);
    #1;
    gmii_rxd = d; gmii_rx_dv = v; gmii_rx_er = e;
  endtask

  task automatic send_frame(input int er_idx, input int pre_er_idx,
                            input bit x_crc, input bit x_rxe, input bit x_pld);
    exp_t e;
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, i == pre_er_idx);
    drive(8'hD5, 1'b1, 1'b0);
    foreach (frm[i]) drive(frm[i], 1'b1, i == er_idx);
    e.len     = (frm.size() > 2047) ? 11'd2047 : 11'(frm.size());
    e.len_e   = (frm.size() < 64) || (frm.size() > 1518);
    e.crc     = x_crc;
    e.rxe     = x_rxe;
`ifdef GMII_RX_PAYLOAD_CMP_EN
    e.pld     = x_pld;
`else
    e.pld     = 1'b0;
`endif
    e.ok      = !(e.crc || e.len_e || e.rxe || e.pld);
    e.chk_hdr = (frm.size() >= 14);
    e.dst = '0; e.src = '0; e.typ = '0;
    if (e.chk_hdr) begin
      e.dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
      e.src = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
      e.typ = {frm[12], frm[13]};
    end
    drive(8'h00, 1'b0, 1'b0);
    e.cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic wait_done(input int target);
    int k;
    k = 0;
    while (done_cnt < target && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (done_cnt < target) begin
      n_bad++; $display("FAIL wait_done: got %0d reports required %0d", done_cnt, target);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (all_out !== '0) begin
      n_bad++; $display("FAIL reset_state: got %h required 0", all_out);
    end
  endtask

  task automatic test_good_frame();
    build_frame(64, 8'hDA);
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(1);
    n_cmp += 2;
    if (good_cnt !== 16'd1) begin n_bad++; $display("FAIL good_cnt_good: got %0d required 1", good_cnt); end
    if (bad_cnt !== 16'd0) begin n_bad++; $display("FAIL bad_cnt_good: got %0d required 0", bad_cnt); end
  endtask

  task automatic test_rx_er();
    build_frame(64, 8'hDA);
    send_frame(39, -1, 1'b0, 1'b1, 1'b0);
    wait_done(2);
    n_cmp += 2;
    if (bad_cnt !== 16'd1) begin n_bad++; $display("FAIL bad_cnt_rxer: got %0d required 1", bad_cnt); end
    if (good_cnt !== 16'd1) begin n_bad++; $display("FAIL good_cnt_rxer: got %0d required 1", good_cnt); end
  endtask

  task automatic test_crc_err();
    build_frame(64, 8'hDA);
    frm[29] = 8'h11;
    send_frame(-1, -1, 1'b1, 1'b0, 1'b1);
    wait_done(3);
    n_cmp++;
    if (bad_cnt !== 16'd2) begin n_bad++; $display("FAIL bad_cnt_crc: got %0d required 2", bad_cnt); end
  endtask

  task automatic test_length();
    frm.delete();
    send_frame(-1, -1, 1'b1, 1'b0, 1'b0);
    wait_done(4);
    build_frame(20, 8'hDA);
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(5);
    build_frame(1600, 8'hDA);
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(6);
    build_frame(2100, 8'hDA);
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(7);
    n_cmp++;
    if (bad_cnt !== 16'd6) begin n_bad++; $display("FAIL bad_cnt_len: got %0d required 6", bad_cnt); end
  endtask

  task automatic test_drop();
    for (int i = 0; i < 3; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hAA, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) drive(8'(i + 3), 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    drive(8'h12, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp += 5;
    if (done_cnt !== 7) begin n_bad++; $display("FAIL drop_no_report: got %0d reports required 7", done_cnt); end
    if (good_cnt !== 16'd1) begin n_bad++; $display("FAIL good_cnt_drop: got %0d required 1", good_cnt); end
    if (bad_cnt !== 16'd6) begin n_bad++; $display("FAIL bad_cnt_drop: got %0d required 6", bad_cnt); end
    if (frame_len !== 11'd2047) begin n_bad++; $display("FAIL len_hold: got %0d required 2047", frame_len); end
    if (dst_mac !== 48'hDA0203040506) begin n_bad++; $display("FAIL dst_hold: got %h required da0203040506", dst_mac); end
    build_frame(64, 8'hDA);
    drive(8'h00, 1'b0, 1'b0);
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(8);
    n_cmp++;
    if (good_cnt !== 16'd2) begin n_bad++; $display("FAIL good_cnt_after_drop: got %0d required 2", good_cnt); end
  endtask

  task automatic test_pre_err();
    build_frame(64, 8'hDA);
    send_frame(-1, 2, 1'b0, 1'b1, 1'b0);
    wait_done(9);
    n_cmp++;
    if (bad_cnt !== 16'd7) begin n_bad++; $display("FAIL bad_cnt_pre_err: got %0d required 7", bad_cnt); end
  endtask

  task automatic test_back_to_back();
    build_frame(64, 8'hDA);
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    build_frame(64, 8'h11);
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(11);
    n_cmp++;
    if (good_cnt !== 16'd4) begin n_bad++; $display("FAIL good_cnt_b2b: got %0d required 4", good_cnt); end
  endtask

  task automatic test_cnt_clr();
    bit seen;
    build_frame(64, 8'hDA);
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(12);
    n_cmp++;
    if (good_cnt !== 16'd5) begin n_bad++; $display("FAIL good_cnt_pre_clr: got %0d required 5", good_cnt); end
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin
      @(negedge clk);
      seen = frame_done;
    end
    n_cmp++;
    if (!seen) begin n_bad++; $display("FAIL clr_done_seen: got no frame_done required one"); end
    cnt_clr = 1'b1;
    @(posedge clk);
    #1 cnt_clr = 1'b0;
    @(negedge clk);
    n_cmp += 2;
    if (good_cnt !== 16'd0) begin n_bad++; $display("FAIL good_cnt_clr: got %0d required 0", good_cnt); end
    if (bad_cnt !== 16'd0) begin n_bad++; $display("FAIL bad_cnt_clr: got %0d required 0", bad_cnt); end
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(14);
    n_cmp++;
    if (good_cnt !== 16'd1) begin n_bad++; $display("FAIL good_cnt_post_clr: got %0d required 1", good_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    build_frame(64, 8'hDA);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0);
    drive(8'hD5, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) drive(frm[i], 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (all_out !== '0) begin n_bad++; $display("FAIL reset_async: got %h required 0", all_out); end
    for (int i = 20; i < 23; i++) drive(frm[i], 1'b1, 1'b0);
    rst_n = 1'b1;
    for (int i = 23; i < 64; i++) drive(frm[i], 1'b1, 1'b0);
    drive(8'h00, 1'b0, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp += 2;
    if (done_cnt !== 14) begin n_bad++; $display("FAIL reset_no_report: got %0d reports required 14", done_cnt); end
    if (all_out !== '0) begin n_bad++; $display("FAIL reset_held: got %h required 0", all_out); end
    send_frame(-1, -1, 1'b0, 1'b0, 1'b0);
    wait_done(15);
    n_cmp++;
    if (good_cnt !== 16'd1) begin n_bad++; $display("FAIL good_cnt_post_rst: got %0d required 1", good_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no completion required finish within 2 ms");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_good_frame();
    test_rx_er();
    test_crc_err();
    test_length();
    test_drop();
    test_pre_err();
    test_back_to_back();
    test_cnt_clr();
    test_reset_mid_frame();
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin n_bad++; $display("FAIL scoreboard_drain: got %0d pending required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
